// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_rx
// Purpose  : PS/2 keyboard receiver in the system clock domain. Synchronises
//            and deglitches the raw PS/2 clock/data pins, receives 11-bit
//            frames (start, 8 data LSB first, odd parity, stop) with a stall
//            timeout, folds E0/F0 prefixes into tagged scan-code entries and
//            buffers them in a show-ahead FIFO with a valid/ready interface.
//            led mirrors the last make (non-break) code.
// Ports    : clock, reset_n        system clock, async active-low reset
//            ps2_clock, ps2_data   raw asynchronous PS/2 pins
//            code/is_ext/is_break  head-of-FIFO entry, meaningful when valid
//            valid, ready          FIFO non-empty / consumer accept
//            err_parity, err_frame one-cycle frame-drop pulses
//            overflow              one-cycle pulse: entry dropped, FIFO full
//            led                   last accepted make code
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       is_ext,
    output logic       is_break,
    output logic       valid,
    input  logic       ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow,
    output logic [7:0] led
);

    localparam int c_FCW = $clog2(FILTER_LEN) + 1;
    localparam int c_TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_AW  = $clog2(FIFO_DEPTH);
    localparam int c_CW  = c_AW + 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    // ------------------------------------------------------------------------
    // Input conditioning: bit 0 = PS/2 clock, bit 1 = PS/2 data.
    // A filtered line only follows the synchronised pin once the pin has
    // disagreed with it for FILTER_LEN consecutive samples, so short glitches
    // never reach the frame logic.
    // ------------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {ps2_data, ps2_clock};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        logic [1:0]       r_sync;
        logic [c_FCW-1:0] r_cnt;
        logic             r_out;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_sync <= 2'b11;
                r_cnt  <= '0;
                r_out  <= 1'b1;
            end else begin
                r_sync <= {r_sync[0], w_raw[gi]};
                if (r_sync[1] != r_out) begin
                    if (r_cnt == c_FCW'(FILTER_LEN - 1)) begin
                        r_out <= r_sync[1];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_FCW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_filt[gi] = r_out;
    end

    // Sample edge: falling edge of the filtered clock; data is taken the same cycle.
    logic r_clk_d;
    logic w_fall;
    logic w_bit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_d <= 1'b1;
        end else begin
            r_clk_d <= w_filt[0];
        end
    end

    assign w_fall = r_clk_d & ~w_filt[0];
    assign w_bit  = w_filt[1];

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [c_TCW-1:0] r_to_cnt;
    logic             w_timeout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE:   if (w_fall && !w_bit) w_state_nxt = c_DATA;
            c_DATA:   if (w_fall && (r_bit_cnt == 3'd7)) w_state_nxt = c_PARITY;
            c_PARITY: if (w_fall) w_state_nxt = c_STOP;
            c_STOP:   if (w_fall) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
        // r_to_cnt counts edge-free cycles; the compare fires on the
        // TIMEOUT_CYCLES-th consecutive cycle without a sample edge.
        if ((r_state != c_IDLE) && !w_fall &&
            (r_to_cnt == c_TCW'(TIMEOUT_CYCLES - 1))) begin
            w_state_nxt = c_IDLE;
            w_timeout   = 1'b1;
        end
    end

    // Frame datapath and frame-check results, all registered so the error
    // pulses and the byte strobe appear the cycle after the stop-bit edge.
    logic       r_byte_vld;
    logic [7:0] r_byte;
    logic       r_err_parity;
    logic       r_err_frame;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_par        <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_vld   <= 1'b0;
            r_byte       <= 8'd0;
            r_err_parity <= 1'b0;
            r_err_frame  <= 1'b0;
        end else begin
            r_byte_vld   <= 1'b0;
            r_err_parity <= 1'b0;
            r_err_frame  <= 1'b0;

            if (w_fall || (r_state == c_IDLE)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TCW'(1);
            end

            if (w_fall) begin
                case (r_state)
                    c_IDLE: begin
                        r_bit_cnt <= 3'd0;
                    end
                    c_DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    c_PARITY: begin
                        r_par <= w_bit;
                    end
                    default: begin
                        // Parity failure takes precedence over a bad stop bit.
                        if (^{r_shift, r_par} == 1'b0) begin
                            r_err_parity <= 1'b1;
                        end else if (!w_bit) begin
                            r_err_frame <= 1'b1;
                        end else begin
                            r_byte_vld <= 1'b1;
                        end
                        r_byte <= r_shift;
                    end
                endcase
            end

            if (w_timeout) begin
                r_err_frame <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Prefix decoder: E0/F0 only set flags; any other byte becomes an entry
    // and consumes the flags, even if the FIFO later drops it.
    // ------------------------------------------------------------------------
    logic       r_ext;
    logic       r_brk;
    logic       r_push;
    logic [9:0] r_push_data;
    logic [7:0] r_led;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 10'd0;
            r_led       <= 8'd0;
        end else begin
            r_push <= 1'b0;
            if (r_byte_vld) begin
                if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_push      <= 1'b1;
                    r_push_data <= {r_byte, r_ext, r_brk};
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                    if (!r_brk) begin
                        r_led <= r_byte;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead FIFO. When full, a simultaneous pop frees the slot being
    // written, so push and pop both succeed.
    // ------------------------------------------------------------------------
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_wr;
    logic [9:0]      w_head;

    assign w_full  = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && ready;
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_push && !w_wr;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked until an entry is written.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign valid      = !w_empty;
    assign code       = valid ? w_head[9:2] : 8'd0;
    assign is_ext     = valid & w_head[1];
    assign is_break   = valid & w_head[0];
    assign err_parity = r_err_parity;
    assign err_frame  = r_err_frame;
    assign overflow   = r_overflow;
    assign led        = r_led;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard_rx
// Purpose  : Self-checking bench for ps2_keyboard_rx. A keyboard model drives
//            PS/2 frames at 12.5 kHz (40 system cycles per bit at 500 kHz);
//            a reference model applies the prefix/FIFO/LED rules to the byte
//            stream and the received entries and pulses are compared to it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int FIFO_DEPTH     = 8;
    localparam int HALF           = 20;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       ready     = 1'b0;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;
    logic       valid;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;
    logic [7:0] led;

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .code       (code),
        .is_ext     (is_ext),
        .is_break   (is_break),
        .valid      (valid),
        .ready      (ready),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow),
        .led        (led)
    );

    always #1000 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- observation ----------------
    logic [9:0] got_q[$];
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int hi_perr = 0, hi_ferr = 0, hi_ovf = 0;
    int perr_cyc = -1, valid_rise_cyc = -1, led_chg_cyc = -1;
    logic p_perr = 0, p_ferr = 0, p_ovf = 0, p_valid = 0;
    logic [7:0] p_led = 8'd0;

    always @(negedge clock) begin
        if (valid && ready) got_q.push_back({code, is_ext, is_break});
        if (err_parity) begin hi_perr++; if (!p_perr) begin n_perr++; perr_cyc = cyc; end end
        if (err_frame)  begin hi_ferr++; if (!p_ferr) n_ferr++; end
        if (overflow)   begin hi_ovf++;  if (!p_ovf)  n_ovf++;  end
        if (valid && !p_valid) valid_rise_cyc = cyc;
        if (led != p_led) led_chg_cyc = cyc;
        p_perr = err_parity; p_ferr = err_frame; p_ovf = overflow;
        p_valid = valid; p_led = led;
    end

    // ---------------- reference model ----------------
    logic [9:0] exp_q[$];
    logic       m_ext = 0, m_brk = 0;
    logic [7:0] m_led = 8'd0;
    int m_perr = 0, m_ferr = 0, m_ovf = 0;

    // Occupancy is entries produced minus entries the consumer has taken.
    function automatic void model_frame(logic [7:0] b, bit bad_par, bit bad_stop);
        if (bad_par) m_perr++;
        else if (bad_stop) m_ferr++;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_brk) m_led = b;
            if (exp_q.size() - got_q.size() >= FIFO_DEPTH) m_ovf++;
            else exp_q.push_back({b, m_ext, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    // ---------------- keyboard driver ----------------
    int stop_cyc = -1;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clock = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(HALF);
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        wait_cyc(5);
        n_checks++;
        if ({code, is_ext, is_break, valid, err_parity, err_frame, overflow, led} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {code, is_ext, is_break, valid, err_parity, err_frame, overflow, led});
        end
        reset_n = 1'b1;
        wait_cyc(20);
        n_checks++;
        if ({valid, led, err_parity, err_frame} !== 11'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h required 0", {valid, led, err_parity, err_frame});
        end
    endtask

    task automatic test_good_frame();
        clear_queues();
        ready = 1'b0;
        valid_rise_cyc = -1;
        led_chg_cyc = -1;
        send_frame(8'h1C, 0, 0, 11);
        model_frame(8'h1C, 0, 0);
        n_checks++;
        if (valid_rise_cyc !== stop_cyc + 2 + FILTER_LEN + 3) begin
            n_fail++;
            $display("FAIL good_valid_latency: got cycle %0d required %0d",
                     valid_rise_cyc, stop_cyc + 2 + FILTER_LEN + 3);
        end
        n_checks++;
        if (led_chg_cyc !== stop_cyc + 2 + FILTER_LEN + 2) begin
            n_fail++;
            $display("FAIL good_led_latency: got cycle %0d required %0d",
                     led_chg_cyc, stop_cyc + 2 + FILTER_LEN + 2);
        end
        n_checks++;
        if (led !== m_led) begin
            n_fail++; $display("FAIL good_led: got %h required %h", led, m_led);
        end
        ready = 1'b1;
        wait_cyc(5);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL good_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL good_entry[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_prefix();
        logic [7:0] seq [4];
        seq = '{8'hE0, 8'hF0, 8'h74, 8'h1C};
        clear_queues();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_frame(seq[i], 0, 0, 11);
            model_frame(seq[i], 0, 0);
            if (i == 2) begin
                wait_cyc(5);
                n_checks++;
                if (led !== m_led) begin
                    n_fail++; $display("FAIL prefix_led_after_break: got %h required %h", led, m_led);
                end
            end
        end
        wait_cyc(5);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL prefix_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL prefix_entry[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_parity_error();
        clear_queues();
        ready = 1'b1;
        send_frame(8'h1C, 1, 0, 11);
        model_frame(8'h1C, 1, 0);
        wait_cyc(5);
        n_checks++;
        if (n_perr !== m_perr) begin
            n_fail++; $display("FAIL parity_pulse_count: got %0d required %0d", n_perr, m_perr);
        end
        n_checks++;
        if (perr_cyc !== stop_cyc + 2 + FILTER_LEN + 1) begin
            n_fail++; $display("FAIL parity_pulse_cycle: got %0d required %0d",
                               perr_cyc, stop_cyc + 2 + FILTER_LEN + 1);
        end
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL parity_no_entry: got %0d entries required 0", got_q.size());
        end
        send_frame(8'h1C, 0, 0, 11);
        model_frame(8'h1C, 0, 0);
        wait_cyc(5);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL parity_recover_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL parity_recover[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        clear_queues();
        ready = 1'b1;
        send_frame(8'h5A, 0, 0, 5);
        m_ferr++;
        wait_cyc(TIMEOUT_CYCLES + 60);
        n_checks++;
        if (n_ferr !== m_ferr) begin
            n_fail++; $display("FAIL timeout_pulse_count: got %0d required %0d", n_ferr, m_ferr);
        end
        send_frame(8'h29, 0, 0, 11);
        model_frame(8'h29, 0, 0);
        wait_cyc(5);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL timeout_recover_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL timeout_recover[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_queues();
        ready = 1'b0;
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
            send_frame(8'(i), 0, 0, 11);
            model_frame(8'(i), 0, 0);
        end
        wait_cyc(5);
        n_checks++;
        if (n_ovf !== m_ovf) begin
            n_fail++; $display("FAIL overflow_pulse_count: got %0d required %0d", n_ovf, m_ovf);
        end
        n_checks++;
        if (led !== m_led) begin
            n_fail++; $display("FAIL overflow_led: got %h required %h", led, m_led);
        end
        ready = 1'b1;
        wait_cyc(FIFO_DEPTH);
        @(negedge clock);
        n_checks++;
        if ({valid, 8'(got_q.size())} !== {1'b0, 8'(FIFO_DEPTH)}) begin
            n_fail++; $display("FAIL overflow_drain_rate: got valid=%b popped=%0d required valid=0 popped=%0d",
                               valid, got_q.size(), FIFO_DEPTH);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL overflow_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL overflow_entry[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch_and_reset();
        clear_queues();
        ready = 1'b1;
        // Short low glitch with data low: would look like a start bit if counted.
        ps2_data = 1'b0;
        ps2_clock = 1'b0;
        wait_cyc(2);
        ps2_clock = 1'b1;
        wait_cyc(HALF);
        ps2_data = 1'b1;
        send_frame(8'h33, 0, 0, 11);
        model_frame(8'h33, 0, 0);
        wait_cyc(5);
        n_checks++;
        if ((got_q.size() !== 1) || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            n_fail++; $display("FAIL glitch_entry: got %0d entries head %h required 1 entry %h",
                               got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, exp_q[0]);
        end
        // Leave an entry pending, then reset in the middle of the next frame.
        clear_queues();
        ready = 1'b0;
        send_frame(8'h15, 0, 0, 11);
        send_frame(8'h4B, 0, 0, 6);
        reset_n = 1'b0;
        wait_cyc(2);
        n_checks++;
        if ({code, is_ext, is_break, valid, err_parity, err_frame, overflow, led} !== 30'd0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got %h required 0",
                     {code, is_ext, is_break, valid, err_parity, err_frame, overflow, led});
        end
        reset_n = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_led = 8'd0;
        clear_queues();
        wait_cyc(10);
        ready = 1'b1;
        send_frame(8'h1C, 0, 0, 11);
        model_frame(8'h1C, 0, 0);
        wait_cyc(5);
        n_checks++;
        if ((got_q.size() !== 1) || (got_q.size() == 1 && got_q[0] !== exp_q[0]) || (led !== m_led)) begin
            n_fail++; $display("FAIL after_reset_frame: got %0d entries led %h required 1 entry %h led %h",
                               got_q.size(), led, exp_q[0], m_led);
        end
    endtask

    task automatic test_random_back_to_back();
        logic [7:0] b;
        bit bp, bs;
        int r;
        clear_queues();
        ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            r  = $urandom_range(0, 9);
            b  = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 7) == 0);
            send_frame(b, bp, bs, 11);
            model_frame(b, bp, bs);
        end
        wait_cyc(10);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL random_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL random_entry[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({n_perr, n_ferr, n_ovf} !== {m_perr, m_ferr, m_ovf}) begin
            n_fail++; $display("FAIL error_totals: got perr=%0d ferr=%0d ovf=%0d required %0d %0d %0d",
                               n_perr, n_ferr, n_ovf, m_perr, m_ferr, m_ovf);
        end
        n_checks++;
        if ({hi_perr, hi_ferr, hi_ovf} !== {n_perr, n_ferr, n_ovf}) begin
            n_fail++; $display("FAIL pulse_width: got high cycles %0d/%0d/%0d for %0d/%0d/%0d pulses",
                               hi_perr, hi_ferr, hi_ovf, n_perr, n_ferr, n_ovf);
        end
        n_checks++;
        if (led !== m_led) begin
            n_fail++; $display("FAIL random_led: got %h required %h", led, m_led);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_prefix();
        test_parity_error();
        test_timeout();
        test_overflow();
        test_glitch_and_reset();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(2000.0 * 90000);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1);
    end

endmodule
`default_nettype wire
